// File: rtl/fetch.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read instruction
// memory and slices each returned word into the fields consumed by decode.
module fetch #(
  parameter int                 IADDR_W  = 8,
  parameter logic [IADDR_W-1:0] RESET_PC = '0,
  parameter logic [4:0]         HALT_OP  = 5'b11111
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall,
  input  logic               branch_taken,
  input  logic [IADDR_W-1:0] branch_target,
  output logic [IADDR_W-1:0] imem_addr,
  input  logic [15:0]        imem_rdata,
  output logic [4:0]         opcode_out,
  output logic [3:0]         nREGA_out,
  output logic [3:0]         nREGB_out,
  output logic [7:0]         opdata_out,
  output logic [IADDR_W-1:0] pc_out,
  output logic               valid_out,
  output logic               halted
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t             state_q, state_d;
  logic [IADDR_W-1:0] pc_q, pc_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [IADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic               held_q, held_d;
  logic [15:0]        hold_word_q, hold_word_d;
  logic [4:0]         opcode_q, opcode_d;
  logic [3:0]         nrega_q, nrega_d;
  logic [3:0]         nregb_q, nregb_d;
  logic [7:0]         opdata_q, opdata_d;
  logic [IADDR_W-1:0] pc_out_q, pc_out_d;
  logic               valid_q, valid_d;
  logic [15:0]        rsp_word;

  // The memory keeps reading at the already-advanced PC while stalled, so the
  // word belonging to rsp_pc is captured on the first stalled edge and replayed.
  assign rsp_word = held_q ? hold_word_q : imem_rdata;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rsp_valid_d = rsp_valid_q;
    rsp_pc_d    = rsp_pc_q;
    held_d      = held_q;
    hold_word_d = hold_word_q;
    opcode_d    = opcode_q;
    nrega_d     = nrega_q;
    nregb_d     = nregb_q;
    opdata_d    = opdata_q;
    pc_out_d    = pc_out_q;
    valid_d     = valid_q;

    if (branch_taken) begin
      state_d     = RUN;
      pc_d        = branch_target;
      rsp_valid_d = 1'b0;
      held_d      = 1'b0;
      opcode_d    = '0;
      nrega_d     = '0;
      nregb_d     = '0;
      opdata_d    = '0;
      valid_d     = 1'b0;
    end else if (stall) begin
      if (!held_q) begin
        held_d      = 1'b1;
        hold_word_d = imem_rdata;
      end
    end else begin
      held_d   = 1'b0;
      opcode_d = '0;
      nrega_d  = '0;
      nregb_d  = '0;
      opdata_d = '0;
      valid_d  = 1'b0;
      if (state_q == RUN) begin
        pc_d        = pc_q + 1'b1;
        rsp_valid_d = 1'b1;
        rsp_pc_d    = pc_q;
        if (rsp_valid_q) begin
          opcode_d = rsp_word[15:11];
          nrega_d  = rsp_word[10:7];
          nregb_d  = rsp_word[6:3];
          opdata_d = rsp_word[7:0];
          pc_out_d = rsp_pc_q;
          valid_d  = 1'b1;
          if (rsp_word[15:11] == HALT_OP) begin
            state_d     = HALTED;
            rsp_valid_d = 1'b0;
            pc_d        = pc_q;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      rsp_valid_q <= 1'b0;
      rsp_pc_q    <= '0;
      held_q      <= 1'b0;
      opcode_q    <= '0;
      nrega_q     <= '0;
      nregb_q     <= '0;
      opdata_q    <= '0;
      pc_out_q    <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_pc_q    <= rsp_pc_d;
      held_q      <= held_d;
      opcode_q    <= opcode_d;
      nrega_q     <= nrega_d;
      nregb_q     <= nregb_d;
      opdata_q    <= opdata_d;
      pc_out_q    <= pc_out_d;
      valid_q     <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    hold_word_q <= hold_word_d;
  end

  assign imem_addr  = pc_q;
  assign opcode_out = opcode_q;
  assign nREGA_out  = nrega_q;
  assign nREGB_out  = nregb_q;
  assign opdata_out = opdata_q;
  assign pc_out     = pc_out_q;
  assign valid_out  = valid_q;
  assign halted     = (state_q == HALTED);

endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: an instruction-stream model predicts each edge's
// outputs into a queue that a negedge monitor pops and compares.
module tb_fetch;
  localparam int         AW    = 8;
  localparam logic [4:0] HALTC = 5'b11111;

  logic          clk = 1'b0;
  logic          reset, stall, branch_taken;
  logic [AW-1:0] branch_target, imem_addr, pc_out;
  logic [15:0]   imem_rdata;
  logic [4:0]    opcode_out;
  logic [3:0]    nREGA_out, nREGB_out;
  logic [7:0]    opdata_out;
  logic          valid_out, halted;

  fetch #(.IADDR_W(AW), .RESET_PC(8'h00), .HALT_OP(HALTC)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .opcode_out(opcode_out), .nREGA_out(nREGA_out), .nREGB_out(nREGB_out),
    .opdata_out(opdata_out), .pc_out(pc_out), .valid_out(valid_out), .halted(halted)
  );

  always #5 clk = ~clk;

  logic [15:0] mem [256];
  always @(posedge clk) imem_rdata <= mem[imem_addr];

  typedef struct packed {
    logic          valid;
    logic [4:0]    op;
    logic [3:0]    ra;
    logic [3:0]    rb;
    logic [7:0]    od;
    logic [AW-1:0] pco;
    logic          hlt;
    logic [AW-1:0] addr;
  } rec_t;

  rec_t q[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: next address to fetch, next address to deliver, whether the
  // first edge after a redirect is still owed as a bubble, and halt status.
  logic [AW-1:0] m_addr, m_exp;
  logic          m_bubble, m_halted;
  rec_t          m_rec;

  task automatic model_edge(input logic rst, input logic stl, input logic br,
                            input logic [AW-1:0] tgt);
    logic [15:0] w;
    if (rst) begin
      m_rec = '0; m_addr = 8'h00; m_exp = 8'h00; m_bubble = 1'b1; m_halted = 1'b0;
    end else if (br) begin
      m_rec.valid = 1'b0; m_rec.op = '0; m_rec.ra = '0; m_rec.rb = '0; m_rec.od = '0;
      m_addr = tgt; m_exp = tgt; m_bubble = 1'b1; m_halted = 1'b0;
    end else if (stl) begin
      // outputs and fetch address unchanged
    end else if (m_halted) begin
      m_rec.valid = 1'b0; m_rec.op = '0; m_rec.ra = '0; m_rec.rb = '0; m_rec.od = '0;
    end else if (m_bubble) begin
      m_rec.valid = 1'b0; m_rec.op = '0; m_rec.ra = '0; m_rec.rb = '0; m_rec.od = '0;
      m_bubble = 1'b0;
      m_addr = m_addr + 8'd1;
    end else begin
      w = mem[m_exp];
      m_rec.valid = 1'b1;
      m_rec.op = w[15:11]; m_rec.ra = w[10:7]; m_rec.rb = w[6:3]; m_rec.od = w[7:0];
      m_rec.pco = m_exp;
      if (w[15:11] == HALTC) m_halted = 1'b1;
      else begin
        m_exp  = m_exp + 8'd1;
        m_addr = m_addr + 8'd1;
      end
    end
    m_rec.hlt  = m_halted;
    m_rec.addr = m_addr;
  endtask

  // Called just after a rising edge: drive inputs, predict, wait for next edge.
  task automatic step(input logic rst, input logic stl, input logic br,
                      input logic [AW-1:0] tgt);
    reset = rst; stall = stl; branch_taken = br; branch_target = tgt;
    model_edge(rst, stl, br, tgt);
    q.push_back(m_rec);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n, input logic stl);
    for (int i = 0; i < n; i++) step(1'b0, stl, 1'b0, 8'h00);
  endtask

  // Monitor
  always @(negedge clk) begin
    rec_t e, g;
    if (q.size() > 0) begin
      e = q.pop_front();
      g = '{valid_out, opcode_out, nREGA_out, nREGB_out, opdata_out, pc_out, halted, imem_addr};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL edge_outputs: got v=%b op=%h ra=%h rb=%h od=%h pc=%h hlt=%b addr=%h, exp v=%b op=%h ra=%h rb=%h od=%h pc=%h hlt=%b addr=%h",
                 g.valid, g.op, g.ra, g.rb, g.od, g.pco, g.hlt, g.addr,
                 e.valid, e.op, e.ra, e.rb, e.od, e.pco, e.hlt, e.addr);
      end
      if (valid_out === 1'b1 && pc_out == 8'h40) begin
        checks++;
        if ({opcode_out, nREGA_out, nREGB_out, opdata_out} !== {5'b10101, 4'b0111, 4'b1001, 8'hCD}) begin
          errors++;
          $display("FAIL slice_abcd: got %b %b %b %h, exp 10101 0111 1001 cd",
                   opcode_out, nREGA_out, nREGB_out, opdata_out);
        end
      end
      if (valid_out === 1'b1 && pc_out == 8'h00) begin
        checks++;
        if ({opcode_out, nREGA_out, nREGB_out, opdata_out} !== {5'b00001, 4'h0, 4'h0, 8'h01}) begin
          errors++;
          $display("FAIL first_word: got %b %h %h %h, exp 00001 0 0 01",
                   opcode_out, nREGA_out, nREGB_out, opdata_out);
        end
      end
      if (valid_out === 1'b1 && pc_out == 8'h05) begin
        checks++;
        if (halted !== 1'b1) begin
          errors++;
          $display("FAIL halt_flag: got halted=%b, exp 1", halted);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [15:0] w;
      w = 16'($urandom);
      if (i < 8 || (i >= 8'h10 && i < 8'h18) || (i >= 8'h40 && i < 8'h48) || i >= 8'hF8)
        w[15] = 1'b0;
      mem[i] = w;
    end
    mem[0] = 16'h0801; mem[1] = 16'h1234; mem[2] = 16'h2345; mem[3] = 16'h3456;
    mem[5] = 16'hF800; mem[8'h40] = 16'hABCD;

    reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_target = '0;
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b1, 1'b0, 1'b0, 8'h00);
    run(3, 1'b0);                      // NOP, pc 0, pc 1
    run(3, 1'b1);                      // stall with pc_out = 1
    run(4, 1'b0);                      // pc 2,3,4,5(HALT)
    run(3, 1'b0);                      // halted NOPs
    run(2, 1'b1);
    step(1'b0, 1'b0, 1'b1, 8'h10);     // resume from halt
    run(4, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h40);
    run(3, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h40);     // branch with stall
    run(3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'hFE);     // wrap
    run(6, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'h00);     // reset mid-stream
    run(3, 1'b0);
    step(1'b0, 1'b0, 1'b1, 8'h03);     // halt reached under stall
    run(2, 1'b0);
    run(3, 1'b1);
    run(4, 1'b0);

    for (int i = 0; i < 600; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 2)       step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
      else if (r < 10) step(1'b0, 1'($urandom), 1'b1, 8'($urandom));
      else if (r < 35) step(1'b0, 1'b1, 1'b0, 8'h00);
      else             step(1'b0, 1'b0, 1'b0, 8'h00);
    end

    for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending, exp 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
